// File: rtl/piano_voice_alloc.sv
// Polyphonic voice allocator: scans 12 keys once per scan_tick and maps presses onto a voice pool.
// Optional VOICE_STEAL_EN: when the pool is full, a press steals the oldest voice instead of dropping.
module piano_voice_alloc #(
  parameter int unsigned NUM_KEYS   = 12,
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic [NUM_KEYS-1:0]     key_in,
  input  logic [3:0]              octave_in,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [4*NUM_VOICES-1:0] voice_key,
  output logic [4*NUM_VOICES-1:0] voice_oct,
  output logic                    update,
  output logic                    busy,
  output logic                    dropped
);

  localparam int unsigned RW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                  state_q;
  logic [3:0]              idx_q;
  logic [NUM_KEYS-1:0]     key_snap_q;
  logic [NUM_KEYS-1:0]     key_prev_q;
  logic [3:0]              oct_snap_q;
  logic [RW-1:0]           rank_q [NUM_VOICES];

  logic [NUM_KEYS-1:0]     key_rev;
  logic [NUM_VOICES-1:0]   act_d;
  logic [4*NUM_VOICES-1:0] vkey_d;
  logic [4*NUM_VOICES-1:0] voct_d;
  logic [RW-1:0]           rank_d [NUM_VOICES];
  logic                    drop_d;
  logic                    pressed;
  logic                    released;
  logic                    free_found;
  int unsigned             free_idx;
  logic                    do_alloc;
  int unsigned             tgt;
  logic [NUM_VOICES-1:0]   freed;
  logic [RW-1:0]           dec;
`ifdef VOICE_STEAL_EN
  int unsigned             steal_idx;
  logic [RW-1:0]           steal_rank;
`endif

  // Internal key index k maps to pin bit NUM_KEYS-1-k.
  always_comb begin
    key_rev = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_rev[k] = key_in[NUM_KEYS-1-k];
    end
  end

  // Voice-table update for the key currently addressed by idx_q.
  always_comb begin
    act_d    = voice_active;
    vkey_d   = voice_key;
    voct_d   = voice_oct;
    drop_d   = 1'b0;
    do_alloc = 1'b0;
    tgt      = 0;
    freed    = '0;
    dec      = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank_d[v] = rank_q[v];
    end

    pressed  = key_snap_q[idx_q] & ~key_prev_q[idx_q];
    released = ~key_snap_q[idx_q] & key_prev_q[idx_q];

    free_found = 1'b0;
    free_idx   = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_active[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = v;
      end
    end

`ifdef VOICE_STEAL_EN
    // Oldest voice has the highest rank; strict compare keeps the lowest index on ties.
    steal_idx  = 0;
    steal_rank = rank_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (rank_q[v] > steal_rank) begin
        steal_idx  = v;
        steal_rank = rank_q[v];
      end
    end
`endif

    if (pressed) begin
      if (free_found) begin
        do_alloc = 1'b1;
        tgt      = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        do_alloc = 1'b1;
        tgt      = steal_idx;
`else
        drop_d   = 1'b1;
`endif
      end
      if (do_alloc) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (v == tgt) begin
            act_d[v]           = 1'b1;
            vkey_d[4*v +: 4]   = idx_q;
            voct_d[4*v +: 4]   = oct_snap_q;
            rank_d[v]          = '0;
          end else if (voice_active[v] && rank_q[v] != RW'(NUM_VOICES - 1)) begin
            rank_d[v] = rank_q[v] + 1'b1;
          end
        end
      end
    end else if (released) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freed[v] = voice_active[v] && (voice_key[4*v +: 4] == idx_q);
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (freed[v]) begin
          act_d[v]  = 1'b0;
          rank_d[v] = '0;
        end else if (voice_active[v]) begin
          dec = '0;
          for (int u = 0; u < NUM_VOICES; u++) begin
            if (freed[u] && rank_q[u] < rank_q[v]) begin
              dec = dec + 1'b1;
            end
          end
          rank_d[v] = rank_q[v] - dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      key_snap_q   <= '0;
      key_prev_q   <= '0;
      oct_snap_q   <= '0;
      voice_active <= '0;
      voice_key    <= '0;
      voice_oct    <= '0;
      update       <= 1'b0;
      dropped      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= '0;
      end
    end else begin
      update  <= 1'b0;
      dropped <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (scan_tick) begin
            key_snap_q <= key_rev;
            oct_snap_q <= octave_in;
            idx_q      <= '0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          voice_active <= act_d;
          voice_key    <= vkey_d;
          voice_oct    <= voct_d;
          dropped      <= drop_d;
          for (int v = 0; v < NUM_VOICES; v++) begin
            rank_q[v] <= rank_d[v];
          end
          if (idx_q == 4'(NUM_KEYS - 1)) begin
            key_prev_q <= key_snap_q;
            update     <= 1'b1;
            state_q    <= StDone;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule
